// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction is in flight at a time. The grant is combinational in the request cycle.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_kill,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem
);

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [2:0] SMAX = 3'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

   state_t     state_reg, state_next;
   logic [2:0] count_reg, count_next;
   logic [2:0] streak_reg, streak_next;
   logic       drop_reg, drop_next;

   logic       fetch_ok;
   logic       grant_d;
   logic       grant_if;
   logic       done;
   logic       if_done;
   logic       d_done;

   // Data normally wins; a fetch that has waited STARVE_MAX data grants gets the next turn.
   always_comb begin
      fetch_ok = if_req & ~if_kill;
      grant_d  = (state_reg == IDLE) & d_req & ~(fetch_ok & (streak_reg == SMAX));
      grant_if = (state_reg == IDLE) & fetch_ok & ~grant_d;
      done     = (state_reg != IDLE) & (count_reg == LAT);
      if_done  = done & (state_reg == BUSY_IF) & ~drop_reg & ~if_kill;
      d_done   = done & (state_reg == BUSY_D);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         count_reg  <= 3'd0;
         streak_reg <= 3'd0;
         drop_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         streak_reg <= streak_next;
         drop_reg   <= drop_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      streak_next = streak_reg;
      drop_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            count_next = 3'd0;
            if (grant_d) begin
               state_next = BUSY_D;
               count_next = 3'd1;
            end else if (grant_if) begin
               state_next = BUSY_IF;
               count_next = 3'd1;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (done) begin
               state_next = IDLE;
               count_next = 3'd0;
            end else begin
               count_next = count_reg + 3'd1;
            end
            // A kill during a fetch lets the memory finish but hides the result.
            drop_next = (state_reg == BUSY_IF) & ~done & (drop_reg | if_kill);
         end
         default: begin
            state_next = IDLE;
            count_next = 3'd0;
         end
      endcase

      if (grant_if || !if_req) begin
         streak_next = 3'd0;
      end else if (grant_d && (streak_reg != SMAX)) begin
         streak_next = streak_reg + 3'd1;
      end
   end

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_funct3 = 3'b000;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      if_valid   = 1'b0;
      if_rdata   = 32'h0;
      d_valid    = 1'b0;
      d_rdata    = 32'h0;
      stall_if   = 1'b0;
      stall_mem  = 1'b0;
      if (rst) begin
         if (grant_d) begin
            mem_en     = 1'b1;
            mem_we     = d_we;
            mem_funct3 = d_funct3;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
         end else if (grant_if) begin
            mem_en     = 1'b1;
            mem_funct3 = 3'b010;
            mem_addr   = if_addr;
         end
         if_valid  = if_done;
         if_rdata  = if_done ? mem_rdata : 32'h0;
         d_valid   = d_done;
         d_rdata   = d_done ? mem_rdata : 32'h0;
         stall_if  = if_req & ~if_done;
         stall_mem = d_req & ~d_done;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single-request vectors plus
// hand-written multi-cycle sequences (contention, starvation, kill, reset).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [2:0]  d_funct3;
   logic        if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [2:0]  mem_funct3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   typedef struct {
      logic        if_req;
      logic        if_kill;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [2:0]  d_funct3;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] rdata;
      logic        exp_en;
      logic        exp_we;
      logic [2:0]  exp_f3;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic        exp_ifv;
      logic        exp_dv;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      string grants;
      int    cyc;

      vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00000013,
                  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h55, 32'hCAFE0001,
                  1'b1, 1'b0, 3'b010, 32'h2000, 32'h55, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 3'b100, 32'h2004, 32'h0, 32'h000000FF,
                  1'b1, 1'b0, 3'b100, 32'h2004, 32'h0, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h3, 32'hDEADBEEF, 32'h12345678,
                  1'b1, 1'b1, 3'b000, 32'h3, 32'hDEADBEEF, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00001111,
                  1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 3'b001, 32'h40, 32'hA5A5, 32'h00002222,
                  1'b1, 1'b1, 3'b001, 32'h40, 32'hA5A5, 1'b0, 1'b1};

      // Reset holds every output low even with requests pending.
      rst = 1'b0;
      idle_inputs();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000;
      @(negedge clk);
      chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_stall_if", {31'b0, stall_if}, 32'h0);
      chk("rst_stall_mem", {31'b0, stall_mem}, 32'h0);
      $display("txn reset: mem_en=%0b stall_if=%0b stall_mem=%0b", mem_en, stall_if, stall_mem);
      next_cycle();
      idle_inputs();
      rst = 1'b1;

      // Table: each vector starts from IDLE, holds requests until T+2, then drops them.
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         if_req = vecs[i].if_req; if_kill = vecs[i].if_kill; if_addr = vecs[i].if_addr;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_funct3 = vecs[i].d_funct3;
         d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata; mem_rdata = vecs[i].rdata;
         @(negedge clk);
         chk($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].exp_en});
         chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
         chk($sformatf("v%0d_mem_funct3", i), {29'b0, mem_funct3}, {29'b0, vecs[i].exp_f3});
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
         chk($sformatf("v%0d_stall_if", i), {31'b0, stall_if}, {31'b0, vecs[i].if_req});
         chk($sformatf("v%0d_stall_mem", i), {31'b0, stall_mem}, {31'b0, vecs[i].d_req});
         next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_if_valid_t1", i), {31'b0, if_valid}, 32'h0);
         chk($sformatf("v%0d_d_valid_t1", i), {31'b0, d_valid}, 32'h0);
         next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_if_valid_t2", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_ifv});
         chk($sformatf("v%0d_d_valid_t2", i), {31'b0, d_valid}, {31'b0, vecs[i].exp_dv});
         chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_ifv ? vecs[i].rdata : 32'h0);
         if (!vecs[i].d_we)
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].exp_dv ? vecs[i].rdata : 32'h0);
         $display("txn vec%0d: mem_addr_T=%h if_valid=%0b d_valid=%0b", i, vecs[i].exp_addr, if_valid, d_valid);
         next_cycle();
         idle_inputs();
         @(negedge clk);
         chk($sformatf("v%0d_idle_after", i), {31'b0, mem_en}, 32'h0);
      end

      // Contention: data at T, d_valid T+2, fetch at T+3, if_valid T+5.
      next_cycle();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000; d_funct3 = 3'b010;
      mem_rdata = 32'hAAAA0000;
      @(negedge clk);
      chk("sim_T_addr", mem_addr, 32'h2000);
      next_cycle(); next_cycle();
      @(negedge clk);
      chk("sim_T2_d_valid", {31'b0, d_valid}, 32'h1);
      chk("sim_T2_if_valid", {31'b0, if_valid}, 32'h0);
      chk("sim_T2_stall_mem", {31'b0, stall_mem}, 32'h0);
      next_cycle();
      d_req = 1'b0;
      mem_rdata = 32'hBBBB0013;
      @(negedge clk);
      chk("sim_T3_mem_en", {31'b0, mem_en}, 32'h1);
      chk("sim_T3_addr", mem_addr, 32'h100);
      chk("sim_T3_funct3", {29'b0, mem_funct3}, 32'h2);
      next_cycle();
      @(negedge clk);
      chk("sim_T4_if_valid", {31'b0, if_valid}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("sim_T5_if_valid", {31'b0, if_valid}, 32'h1);
      chk("sim_T5_if_rdata", if_rdata, 32'hBBBB0013);
      $display("txn contention: fetch completed if_rdata=%h", if_rdata);
      next_cycle();
      idle_inputs();

      // Starvation: both held continuously, record grant order.
      next_cycle();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000; d_funct3 = 3'b010;
      grants = "";
      cyc = 0;
      while (grants.len() < 6 && cyc < 40) begin
         @(negedge clk);
         if (mem_en) grants = {grants, (mem_addr == 32'h100) ? "F" : "D"};
         cyc++;
         next_cycle();
      end
      checks++;
      if (grants != "DDDDFD") begin
         errors++;
         $display("FAIL starve_order actual=%s required=DDDDFD", grants);
      end
      $display("txn starvation: grant order %s", grants);
      idle_inputs();
      repeat (4) next_cycle();

      // Kill: fetch at T, kill at T+1, store at T+3 completes at T+5.
      if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h77770000;
      @(negedge clk);
      chk("kill_T_mem_en", {31'b0, mem_en}, 32'h1);
      next_cycle();
      if_req = 1'b0; if_kill = 1'b1;
      @(negedge clk);
      next_cycle();
      if_kill = 1'b0;
      @(negedge clk);
      chk("kill_T2_if_valid", {31'b0, if_valid}, 32'h0);
      chk("kill_T2_if_rdata", if_rdata, 32'h0);
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h400; d_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("kill_T3_mem_we", {31'b0, mem_we}, 32'h1);
      chk("kill_T3_wdata", mem_wdata, 32'hDEADBEEF);
      next_cycle(); next_cycle();
      @(negedge clk);
      chk("kill_T5_d_valid", {31'b0, d_valid}, 32'h1);
      $display("txn kill: store acked d_valid=%0b", d_valid);
      next_cycle();
      idle_inputs();

      // Reset mid-transaction: abandoned, re-request granted right after release.
      next_cycle();
      d_req = 1'b1; d_addr = 32'h2100; d_funct3 = 3'b010; mem_rdata = 32'h5555AAAA;
      @(negedge clk);
      chk("rmid_T_mem_en", {31'b0, mem_en}, 32'h1);
      next_cycle();
      rst = 1'b0;
      #1;
      chk("rmid_T1_mem_en", {31'b0, mem_en}, 32'h0);
      chk("rmid_T1_stall_mem", {31'b0, stall_mem}, 32'h0);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_T2_d_valid", {31'b0, d_valid}, 32'h0);
      chk("rmid_T2_regrant", {31'b0, mem_en}, 32'h1);
      next_cycle(); next_cycle();
      @(negedge clk);
      chk("rmid_T4_d_valid", {31'b0, d_valid}, 32'h1);
      chk("rmid_T4_d_rdata", d_rdata, 32'h5555AAAA);
      $display("txn reset_mid: regrant completed d_rdata=%h", d_rdata);
      next_cycle();
      idle_inputs();
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, cycles from memory-enable cycle to read data valid (legal 1..7).
REQ-002 Parameter STARVE_MAX, default 4, max consecutive data grants while a fetch request waits (legal 1..7).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 if_req  in  1  fetch request, level, held until if_valid or if_kill.
REQ-007 if_addr  in  32  fetch address.
REQ-008 if_kill  in  1  redirect; cancels pending or outstanding fetch.
REQ-009 if_valid  out  1  one-cycle fetch completion pulse; if_rdata  out  32  instruction word.
REQ-010 d_req  in  1  data request, level, held until d_valid.
REQ-011 d_we  in  1  store when 1, load when 0; d_funct3  in  3  access size/sign; d_addr  in  32; d_wdata  in  32.
REQ-012 d_valid  out  1  one-cycle data completion pulse (loads and stores); d_rdata  out  32  load data.
REQ-013 mem_en  out  1; mem_we  out  1; mem_funct3  out  3; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32  (valid MEM_LAT cycles after mem_en).
REQ-014 stall_if  out  1; stall_mem  out  1  stall requests to the hazard unit.

Function
REQ-015 FSM states IDLE, BUSY_IF, BUSY_D; one memory transaction outstanding at most.
REQ-016 In IDLE, a grant SHALL occur combinationally in the request cycle: mem_en=1 and mem_addr/we/funct3/wdata driven from the granted requester; next state BUSY_IF or BUSY_D.
REQ-017 Fetch grants drive mem_we=0, mem_funct3=3'b010.
REQ-018 When both request in IDLE, data SHALL win unless streak==STARVE_MAX, then fetch wins.
REQ-019 streak (3-bit): +1 per data grant while if_req=1, saturating at STARVE_MAX; cleared on any fetch grant or when if_req=0.
REQ-020 Busy counter loads 1 on grant, increments each busy cycle; when count==MEM_LAT the owner's valid pulses for one cycle, rdata = mem_rdata, FSM returns to IDLE.
REQ-021 Grant in cycle T SHALL complete in cycle T+MEM_LAT; the next grant is no earlier than T+MEM_LAT+1.
REQ-022 mem_en=0 in every cycle except grant cycles; outputs of non-granted side held 0 (valid) / 0 (rdata).
REQ-023 if_kill in IDLE SHALL block fetch grant that cycle; data may still be granted.
REQ-024 if_kill during BUSY_IF SHALL set a drop flag: transaction runs to completion but if_valid is suppressed; flag clears on return to IDLE.
REQ-025 if_kill during BUSY_D has no effect on the data transaction.
REQ-026 stall_if = if_req & ~if_valid; stall_mem = d_req & ~d_valid.
REQ-027 A requester deasserting request while BUSY (other than via if_kill) SHALL NOT abort the transaction; completion pulse still issued.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, counter=0, streak=0, drop flag=0, and all outputs 0 (mem_en, mem_we, valids, rdata, stalls gated).
REQ-029 Reset mid-transaction abandons it; no valid pulse is issued for it after rst returns to 1.
REQ-030 First grant possible in the first clock cycle with rst=1.

Verification
REQ-031 Single fetch, MEM_LAT=2: if_req, if_addr=0x100 at T -> mem_en=1, mem_addr=0x100 at T; if_valid=1, if_rdata=mem_rdata at T+2; stall_if=1 at T..T+1.
REQ-032 Simultaneous: d_req load 0x2000 and if_req at T -> data granted T, d_valid T+2, fetch granted T+3, if_valid T+5.
REQ-033 Starvation, STARVE_MAX=4: d_req and if_req held continuously -> 4 data grants, then one fetch grant, then data resumes; streak back to 0.
REQ-034 Kill: fetch granted T, if_kill at T+1 -> no if_valid at T+2; store granted T+3 with mem_we=1, mem_wdata=0xDEADBEEF, d_valid at T+5.
REQ-035 Reset mid-op: data granted T, rst=0 at T+1 for one cycle -> all outputs 0 immediately, no d_valid at T+2, re-request granted first cycle after release.
REQ-036 Store ack: d_we=1, d_funct3=3'b000, d_addr=0x3 -> mem_funct3=000, mem_addr=0x3, d_valid pulse, d_rdata ignored, if_valid stays 0.
